shift_packer: RTL and testbench

//  Parametrised serial-to-parallel packer; one block replaces the fixed-width input shift registers (8->128, 6->96, 12->96, 20->160, 48->96, 80->160).

---
 rtl/shift_packer.sv | 82 ++++++++
 tb/tb_shift_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_packer.sv
// Parametrised serial-to-parallel packer: N = OUT_W/IN_W beats per word, one-word
// output holding register, and a synchronous flush that emits a zero-padded partial word.
module shift_packer #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 128,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CNT_W    = $clog2(OUT_W / IN_W + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_partial,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned     N    = OUT_W / IN_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [OUT_W-1:0] sr;
  logic [OUT_W-1:0] sr_shift;
  logic [OUT_W-1:0] partial_word;
  logic             flush_pending;
  logic             slot_free;
  logic             at_last;
  logic             accept;
  int unsigned      pad_sh;

  always_comb begin
    slot_free = !out_valid || out_ready;
    at_last   = (count == LAST);
    in_ready  = !flush_pending && !(at_last && !slot_free);
    accept    = in_valid && in_ready;
    pad_sh    = (N - 32'(count)) * IN_W;
    // Beats always sit at the "latest" end of sr, so a single shift by the missing
    // beats both aligns the partial word and supplies the zero padding.
    if (MSB_FIRST) begin
      sr_shift     = {sr[OUT_W-IN_W-1:0], in_data};
      partial_word = sr << pad_sh;
    end else begin
      sr_shift     = {in_data, sr[OUT_W-1:IN_W]};
      partial_word = sr >> pad_sh;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sr            <= '0;
      count         <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_partial   <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) sr <= sr_shift;

      if (accept && at_last) begin
        out_data    <= sr_shift;
        out_valid   <= 1'b1;
        out_partial <= 1'b0;
        count       <= '0;
      end else if (flush_pending && slot_free) begin
        out_data      <= partial_word;
        out_valid     <= 1'b1;
        out_partial   <= 1'b1;
        count         <= '0;
        flush_pending <= 1'b0;
      end else begin
        if (accept) count <= count + CNT_W'(1);
        // A flush with nothing buffered (after this cycle's beat) is dropped.
        if (flush && (accept || count != '0)) flush_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_packer.sv
// Directed bench for shift_packer: MSB/LSB-first 8->128 instances sharing one
// stimulus stream, plus a 12->96 instance for partial-word flush.
module tb_shift_packer;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic         a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [7:0]   a_in_data = '0;
  logic         a_in_ready, a_out_valid, a_out_partial;
  logic [127:0] a_out_data;
  logic [4:0]   a_count;

  logic         b_in_ready, b_out_valid, b_out_partial;
  logic [127:0] b_out_data;
  logic [4:0]   b_count;

  logic         c_flush = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b1;
  logic [11:0]  c_in_data = '0;
  logic         c_in_ready, c_out_valid, c_out_partial;
  logic [95:0]  c_out_data;
  logic [3:0]   c_count;

  shift_packer #(.IN_W(8), .OUT_W(128), .MSB_FIRST(1'b1)) u_a (
    .clock(clock), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_partial(a_out_partial),
    .count(a_count));

  shift_packer #(.IN_W(8), .OUT_W(128), .MSB_FIRST(1'b0)) u_b (
    .clock(clock), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(b_in_ready), .in_data(a_in_data), .out_valid(b_out_valid),
    .out_ready(a_out_ready), .out_data(b_out_data), .out_partial(b_out_partial),
    .count(b_count));

  shift_packer #(.IN_W(12), .OUT_W(96), .MSB_FIRST(1'b1)) u_c (
    .clock(clock), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_partial(c_out_partial),
    .count(c_count));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One beat into the A/B pair; caller guarantees in_ready is high.
  task automatic send_a(input logic [7:0] d, input logic fl);
    a_in_data  = d;
    a_in_valid = 1'b1;
    a_flush    = fl;
    tick();
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
  endtask

  localparam logic [127:0] W_T1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] W_T2  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] W_1   = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] W_2   = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] W_3   = 128'h303132333435363738393A3B3C3D3E3F;
  localparam logic [127:0] W_6   = 128'h505152535455565758595A5B5C5D5E5F;
  localparam logic [95:0]  W_T4  = 96'hABC123456000000000000000;

  initial begin
    int unsigned b;
    logic        rdy;

    // Reset
    #2;
    check("rst_valid", 128'(a_out_valid), 128'(0));
    check("rst_count", 128'(a_count), 128'(0));
    check("rst_data", a_out_data, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", 128'(a_in_ready), 128'(1));

    // T1/T2: 16 beats, both bit orders
    for (int i = 0; i < 16; i++) begin
      send_a(8'(i), 1'b0);
      if (i == 14) begin
        check("t1_pre_valid", 128'(a_out_valid), 128'(0));
        check("t1_pre_count", 128'(a_count), 128'(15));
      end
    end
    check("t1_valid", 128'(a_out_valid), 128'(1));
    check("t1_data", a_out_data, W_T1);
    check("t1_partial", 128'(a_out_partial), 128'(0));
    check("t1_count", 128'(a_count), 128'(0));
    check("t2_data", b_out_data, W_T2);
    check("t2_valid", 128'(b_out_valid), 128'(1));
    tick();
    check("t1_drain_valid", 128'(a_out_valid), 128'(0));
    check("t1_drain_hold", a_out_data, W_T1);

    // T3: stalled consumer, 40 attempts
    a_out_ready = 1'b0;
    b = 0;
    for (int i = 0; i < 40; i++) begin
      a_in_data  = 8'(8'h10 + b);
      a_in_valid = 1'b1;
      #1;
      check("t3_ready", 128'(a_in_ready), 128'(b != 31));
      rdy = a_in_ready;
      tick();
      if (rdy) b++;
      if (b >= 16) check("t3_hold", a_out_data, W_1);
    end
    check("t3_accepted", 128'(b), 128'(31));
    check("t3_count", 128'(a_count), 128'(15));
    check("t3_valid", 128'(a_out_valid), 128'(1));
    a_out_ready = 1'b1;
    a_in_data   = 8'h2F;
    #1;
    check("t3_rel_ready", 128'(a_in_ready), 128'(1));
    tick();
    a_in_valid = 1'b0;
    check("t3_word2", a_out_data, W_2);
    check("t3_word2_valid", 128'(a_out_valid), 128'(1));
    tick();
    check("t3_empty", 128'(a_out_valid), 128'(0));

    // T5: flush with nothing buffered, then flush on the completing beat
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    tick();
    check("t5_idle_valid", 128'(a_out_valid), 128'(0));
    check("t5_idle_ready", 128'(a_in_ready), 128'(1));
    for (int i = 0; i < 16; i++) send_a(8'(8'h30 + i), i == 15);
    check("t5_word", a_out_data, W_3);
    check("t5_partial", 128'(a_out_partial), 128'(0));
    tick();
    tick();
    check("t5_no_extra", 128'(a_out_valid), 128'(0));
    check("t5_ready", 128'(a_in_ready), 128'(1));

    // T4: 12->96 partial flush, flush held high for three cycles
    for (int i = 0; i < 3; i++) begin
      c_in_data  = (i == 0) ? 12'hABC : (i == 1) ? 12'h123 : 12'h456;
      c_in_valid = 1'b1;
      tick();
    end
    c_in_valid = 1'b0;
    c_flush    = 1'b1;
    tick();
    check("t4_pending_ready", 128'(c_in_ready), 128'(0));
    tick();
    check("t4_valid", 128'(c_out_valid), 128'(1));
    check("t4_data", 128'(c_out_data), 128'(W_T4));
    check("t4_partial", 128'(c_out_partial), 128'(1));
    check("t4_count", 128'(c_count), 128'(0));
    tick();
    c_flush = 1'b0;
    check("t4_single", 128'(c_out_valid), 128'(0));
    tick();
    check("t4_no_empty", 128'(c_out_valid), 128'(0));
    check("t4_ready", 128'(c_in_ready), 128'(1));

    // T6: async reset with a stalled word and a partial word in flight
    a_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_a(8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 5; i++) send_a(8'(8'h60 + i), 1'b0);
    check("t6_pre_valid", 128'(a_out_valid), 128'(1));
    check("t6_pre_count", 128'(a_count), 128'(5));
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(a_out_valid), 128'(0));
    check("t6_rst_count", 128'(a_count), 128'(0));
    check("t6_rst_data", a_out_data, '0);
    #1 rst_n = 1'b1;
    tick();
    a_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_a(8'(8'h50 + i), 1'b0);
    check("t6_word", a_out_data, W_6);
    check("t6_partial", 128'(a_out_partial), 128'(0));
    check("t6_valid", 128'(a_out_valid), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
